// File: rtl/pipe_hazard_unit.sv
// Hazard controller beside ID: tracks in-flight destinations from EX to WB and
// produces the load-use stall, the IF/ID flush and the registered EX forwarding selects.
module pipe_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_FWD = 2,
  parameter int ALU_FWD  = 1,
  parameter int BR_STAGE = 1,
  localparam int FW      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_we_i,
  input  logic [REG_AW-1:0] id_wa_i,
  input  logic              id_load_i,
  output logic              stall_o,
  output logic              flush_ifid_o,
  output logic [FW-1:0]     fwd_a_o,
  output logic [FW-1:0]     fwd_b_o,
  output logic [DEPTH-1:0]  stage_valid_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             we_q, we_d;
  logic [DEPTH-1:0]             load_q, load_d;
  logic [DEPTH-1:0][REG_AW-1:0] wa_q, wa_d;
  logic [FW-1:0]                fwd_a_q, fwd_a_d;
  logic [FW-1:0]                fwd_b_q, fwd_b_d;

  logic [DEPTH-1:0] match_a, match_b;
  logic [FW-1:0]    sel_a, sel_b;
  logic             stall_a, stall_b;
  logic             issue;

  // Per-stage address match for each used, non-r0 source
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = valid_q[i] & we_q[i] & id_use_rs_i & (id_rs_i != '0) & (wa_q[i] == id_rs_i);
      match_b[i] = valid_q[i] & we_q[i] & id_use_rt_i & (id_rt_i != '0) & (wa_q[i] == id_rt_i);
    end
  end

  // Scan oldest to youngest so the youngest match wins; WB producers never forward
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_a[i]) begin
        sel_a   = (i <= DEPTH - 2) ? FW'(i + 1) : '0;
        stall_a = (i + 1) < (load_q[i] ? LOAD_FWD : ALU_FWD);
      end
      if (match_b[i]) begin
        sel_b   = (i <= DEPTH - 2) ? FW'(i + 1) : '0;
        stall_b = (i + 1) < (load_q[i] ? LOAD_FWD : ALU_FWD);
      end
    end
  end

  assign stall_o      = id_valid_i & ~hold_i & ~flush_i & (stall_a | stall_b);
  assign flush_ifid_o = flush_i & ~hold_i;
  assign issue        = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    load_d  = load_q;
    wa_d    = wa_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!hold_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        load_d[k]  = load_q[k-1];
        wa_d[k]    = wa_q[k-1];
      end
      valid_d[0] = issue;
      we_d[0]    = id_we_i;
      load_d[0]  = id_load_i;
      wa_d[0]    = id_wa_i;
      // Squash the slots the wrong-path instructions would occupy after the shift
      if (flush_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k <= BR_STAGE) valid_d[k] = 1'b0;
        end
      end
      fwd_a_d = issue ? sel_a : '0;
      fwd_b_d = issue ? sel_b : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      we_q    <= '0;
      load_q  <= '0;
      wa_q    <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      load_q  <= load_d;
      wa_q    <= wa_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_o       = fwd_a_q;
  assign fwd_b_o       = fwd_b_q;
  assign stage_valid_o = valid_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: a pipeline model predicts every cycle's
// stall/flush and the following cycle's forward selects and stage valids.
module tb_pipe_hazard_unit;
  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_FWD = 2;
  localparam int ALU_FWD  = 1;
  localparam int BR_STAGE = 1;
  localparam int FW       = 2;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic hold_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
  logic [REG_AW-1:0] id_rs_i = '0, id_rt_i = '0, id_wa_i = '0;
  logic id_use_rs_i = 1'b0, id_use_rt_i = 1'b0, id_we_i = 1'b0, id_load_i = 1'b0;
  logic stall_o, flush_ifid_o;
  logic [FW-1:0] fwd_a_o, fwd_b_o;
  logic [DEPTH-1:0] stage_valid_o;

  pipe_hazard_unit dut (
    .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i), .id_we_i(id_we_i),
    .id_wa_i(id_wa_i), .id_load_i(id_load_i), .stall_o(stall_o),
    .flush_ifid_o(flush_ifid_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stage_valid_o(stage_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic stall; logic fl; } comb_t;
  typedef struct { int cyc; logic [FW-1:0] fa; logic [FW-1:0] fb; logic [DEPTH-1:0] sv; } reg_t;
  comb_t cq[$];
  reg_t  rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: in-flight instruction records, index = pipeline stage after ID
  bit m_v[DEPTH];
  bit m_we[DEPTH];
  bit m_ld[DEPTH];
  int m_wa[DEPTH];
  int m_fa = 0;
  int m_fb = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int youngest(input int r, input bit use_src);
    if (!use_src || r == 0) return -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_we[i] && m_wa[i] == r) return i;
    return -1;
  endfunction

  // Producer at stage i is still too young for the consumer to proceed
  function automatic bit too_close(input int i);
    if (i < 0) return 1'b0;
    return (i + 1) < (m_ld[i] ? LOAD_FWD : ALU_FWD);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_we[i] = 0; m_ld[i] = 0; m_wa[i] = 0;
    end
    m_fa = 0;
    m_fb = 0;
  endfunction

  task automatic drive(input bit h, input bit fl, input bit v, input int rs, input int rt,
                       input bit urs, input bit urt, input bit we, input int wa, input bit ld);
    int ia, ib;
    bit es, iss;
    comb_t c;
    reg_t r;
    @(posedge clk);
    #1;
    hold_i = h; flush_i = fl; id_valid_i = v;
    id_rs_i = REG_AW'(rs); id_rt_i = REG_AW'(rt);
    id_use_rs_i = urs; id_use_rt_i = urt;
    id_we_i = we; id_wa_i = REG_AW'(wa); id_load_i = ld;
    ia = youngest(rs, urs);
    ib = youngest(rt, urt);
    es = 0;
    if (!h) begin
      es  = v && !fl && (too_close(ia) || too_close(ib));
      iss = v && !es && !fl;
      m_fa = (iss && ia >= 0 && ia <= DEPTH - 2) ? ia + 1 : 0;
      m_fb = (iss && ib >= 0 && ib <= DEPTH - 2) ? ib + 1 : 0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
        m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_wa[k] = m_wa[k-1];
      end
      m_v[0] = iss; m_we[0] = we; m_ld[0] = ld; m_wa[0] = wa;
      if (fl) for (int k = 0; k <= BR_STAGE && k < DEPTH; k++) m_v[k] = 0;
    end
    c.cyc = cyc; c.stall = es; c.fl = fl && !h;
    cq.push_back(c);
    r.cyc = cyc + 1; r.fa = FW'(m_fa); r.fb = FW'(m_fb);
    for (int k = 0; k < DEPTH; k++) r.sv[k] = m_v[k];
    rq.push_back(r);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare whatever is due at this falling edge
  always @(negedge clk) begin
    if (rst_i) begin
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        comb_t c;
        c = cq.pop_front();
        check("stall_o", 32'(stall_o), 32'(c.stall));
        check("flush_ifid_o", 32'(flush_ifid_o), 32'(c.fl));
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        reg_t r;
        r = rq.pop_front();
        check("fwd_a_o", 32'(fwd_a_o), 32'(r.fa));
        check("fwd_b_o", 32'(fwd_b_o), 32'(r.fb));
        check("stage_valid_o", 32'(stage_valid_o), 32'(r.sv));
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 6 && (cq.size() > 0 || rq.size() > 0); k++) @(posedge clk);
    check("scoreboard_drained", 32'(cq.size() + rq.size()), 32'd0);
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_stage_valid", 32'(stage_valid_o), 32'd0);
    check("reset_fwd_a", 32'(fwd_a_o), 32'd0);
    check("reset_fwd_b", 32'(fwd_b_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    // ALU chain back-to-back, then with one NOP between
    drive(0, 0, 1, 1, 2, 1, 1, 1, 3, 0);
    drive(0, 0, 1, 3, 5, 1, 1, 1, 4, 0);
    drive(0, 0, 1, 1, 2, 1, 1, 1, 7, 0);
    idle();
    drive(0, 0, 1, 7, 0, 1, 0, 1, 8, 0);
    idle(); idle(); idle();
    // Load-use: one bubble then forward from stage 2
    drive(0, 0, 1, 0, 0, 0, 0, 1, 2, 1);
    drive(0, 0, 1, 2, 2, 1, 1, 1, 6, 0);
    drive(0, 0, 1, 2, 2, 1, 1, 1, 6, 0);
    idle(); idle(); idle();
    // r0 destination and unused source
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 0, 1, 1, 1, 1, 0);
    drive(0, 0, 1, 9, 0, 0, 0, 1, 9, 1);
    drive(0, 0, 1, 9, 9, 0, 0, 1, 10, 0);
    idle(); idle(); idle();
    // Branch flush with younger instructions behind the branch
    drive(0, 0, 1, 0, 0, 0, 0, 1, 11, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 12, 0);
    drive(0, 1, 1, 12, 0, 1, 0, 1, 13, 0);
    idle(); idle(); idle();
    // Hold during a pending load-use, then a single stall
    drive(0, 0, 1, 0, 0, 0, 0, 1, 5, 1);
    drive(1, 0, 1, 5, 0, 1, 0, 1, 6, 0);
    drive(1, 1, 1, 5, 0, 1, 0, 1, 6, 0);
    drive(1, 0, 1, 5, 0, 1, 0, 1, 6, 0);
    drive(0, 0, 1, 5, 0, 1, 0, 1, 6, 0);
    drive(0, 0, 1, 5, 0, 1, 0, 1, 6, 0);
    idle(); idle(); idle();

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 8,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 2) == 0);
    end

    // Fill the scoreboard, freeze it, then reset asynchronously
    drive(0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 2, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 3, 0);
    drive(0, 0, 1, 3, 2, 1, 1, 1, 4, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drain();
    #7;
    rst_i = 1'b0;
    #1;
    check("async_reset_stage_valid", 32'(stage_valid_o), 32'd0);
    check("async_reset_fwd_a", 32'(fwd_a_o), 32'd0);
    check("async_reset_fwd_b", 32'(fwd_b_o), 32'd0);
    model_reset();
    hold_i = 1'b0; id_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;

    // No stale forwarding after reset
    drive(0, 0, 1, 3, 2, 1, 1, 1, 4, 0);
    for (int n = 0; n < 60; n++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 8,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 2) == 0);
    end
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
